// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface definitions: default bus widths and arbiter state encodings.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, data-priority with fetch anti-starvation streak.
// Latency: grant on the edge after the request is seen in IDLE, done one cycle after ack (2 cycles min).
// Backpressure: access holds in GNT until mem_ack_i; requesters hold req/operands until their done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_done_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_done_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int unsigned CNT_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    arb_state_e       state;
    logic [CNT_W-1:0] streak;

    logic if_elig;
    logic d_elig;
    logic at_max;
    logic gnt_i;
    logic gnt_d;

    assign at_max  = (streak == STREAK_MAX);
    assign if_elig = if_req_i && !if_done_o;
    assign d_elig  = d_req_i && !d_done_o;

    // A data requester still in its done cycle keeps priority, so fetch cannot slip in
    // between consecutive data accesses unless the streak has saturated.
    assign gnt_d = (state == ST_IDLE) && enable_i && d_elig && !(if_elig && at_max);
    assign gnt_i = (state == ST_IDLE) && enable_i && if_elig && (at_max || !d_req_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            streak      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            if_done_o   <= 1'b0;
            d_done_o    <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            if_done_o <= 1'b0;
            d_done_o  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!if_req_i) begin
                        streak <= '0;
                    end
                    if (gnt_i) begin
                        state       <= ST_GNT_I;
                        busy_o      <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        mem_be_o    <= '1;
                        streak      <= '0;
                    end else if (gnt_d) begin
                        state       <= ST_GNT_D;
                        busy_o      <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        mem_be_o    <= d_be_i;
                        if (if_elig && !at_max) begin
                            streak <= streak + CNT_W'(1);
                        end
                    end
                end
                ST_GNT_I: begin
                    if (mem_ack_i) begin
                        state      <= ST_IDLE;
                        busy_o     <= 1'b0;
                        mem_req_o  <= 1'b0;
                        if_done_o  <= 1'b1;
                        if_rdata_o <= mem_rdata_i;
                    end
                end
                ST_GNT_D: begin
                    if (mem_ack_i) begin
                        state     <= ST_IDLE;
                        busy_o    <= 1'b0;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        d_done_o  <= 1'b1;
                        if (!mem_we_o) begin
                            d_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_o    <= 1'b0;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an in-order grant scoreboard and a wait-state memory model.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gnt_t;

    gnt_t sb[$];
    gnt_t cur;
    logic cur_vld  = 1'b0;
    logic prev_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   mem_delay = 0;
    int   wait_cnt  = 0;
    logic force_ack = 1'b0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_i(input logic [31:0] a);
        sb.push_back('{we: 1'b0, addr: a, wdata: 32'h0, be: 4'hF});
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        sb.push_back('{we: we, addr: a, wdata: wd, be: be});
    endtask

    // Memory: acks after mem_delay wait cycles; rdata is junk whenever ack is low.
    always @(negedge clk_i) begin
        if (mem_req_o && wait_cnt >= mem_delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_model(mem_addr_o);
            wait_cnt    = 0;
        end else begin
            mem_ack_i   = force_ack;
            mem_rdata_i = 32'hBAD0_0000 ^ wait_cnt;
            if (mem_req_o) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    // Grant monitor: each new mem_req_o pops the next expected access; fields must hold while requesting.
    always @(negedge clk_i) begin
        if (mem_req_o && !prev_req) begin
            chk("grant_expected", 64'(sb.size() != 0), 64'd1);
            cur_vld = (sb.size() != 0);
            if (cur_vld) cur = sb.pop_front();
        end
        if (mem_req_o && cur_vld) begin
            chk("grant_addr", 64'(mem_addr_o), 64'(cur.addr));
            chk("grant_we", 64'(mem_we_o), 64'(cur.we));
            chk("grant_be", 64'(mem_be_o), 64'(cur.be));
            if (cur.we) chk("grant_wdata", 64'(mem_wdata_o), 64'(cur.wdata));
        end
        if (!mem_req_o) cur_vld = 1'b0;
        prev_req = mem_req_o;
    end

    initial begin
        int dn;
        int fetch_at;
        reset_i = 1'b1; enable_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        repeat (2) tick();

        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_we", 64'(mem_we_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_mem_wdata_be", 64'({mem_wdata_o, mem_be_o}), 64'd0);
        chk("rst_dones", 64'({if_done_o, d_done_o}), 64'd0);
        chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // Single zero-wait fetch.
        reset_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        push_i(32'h40);
        tick();
        chk("f1_req", 64'(mem_req_o), 64'd1);
        chk("f1_we", 64'(mem_we_o), 64'd0);
        chk("f1_busy", 64'(busy_o), 64'd1);
        chk("f1_nodone", 64'(if_done_o), 64'd0);
        tick();
        chk("f1_done", 64'(if_done_o), 64'd1);
        chk("f1_rdata", 64'(if_rdata_o), 64'h8C01_0004);
        chk("f1_req_drop", 64'(mem_req_o), 64'd0);
        chk("f1_we_low", 64'(mem_we_o), 64'd0);
        chk("f1_busy_low", 64'(busy_o), 64'd0);
        if_req_i = 1'b0;
        tick();
        chk("f1_done_pulse", 64'(if_done_o), 64'd0);

        // Data load with 3 wait cycles.
        mem_delay = 3;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; d_wdata_i = '0; d_be_i = 4'hF;
        push_d(1'b0, 32'h300, 32'h0, 4'hF);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("ld_wait_req", 64'(mem_req_o), 64'd1);
            chk("ld_wait_busy", 64'(busy_o), 64'd1);
            chk("ld_wait_nodone", 64'(d_done_o), 64'd0);
            tick();
        end
        chk("ld_done", 64'(d_done_o), 64'd1);
        chk("ld_rdata", 64'(d_rdata_o), 64'(mem_model(32'h300)));
        chk("ld_req_drop", 64'(mem_req_o), 64'd0);
        d_req_i = 1'b0;
        tick();
        chk("ld_done_pulse", 64'(d_done_o), 64'd0);
        chk("ld_no_regrant", 64'(mem_req_o), 64'd0);
        chk("ld_idle", 64'(busy_o), 64'd0);

        // Simultaneous fetch and store: store first, then fetch.
        mem_delay = 0;
        if_req_i = 1'b1; if_addr_i = 32'h44;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF;
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        push_i(32'h44);
        tick();
        chk("st_we", 64'(mem_we_o), 64'd1);
        chk("st_addr", 64'(mem_addr_o), 64'h100);
        tick();
        chk("st_done", 64'(d_done_o), 64'd1);
        chk("st_rdata_hold", 64'(d_rdata_o), 64'(mem_model(32'h300)));
        d_req_i = 1'b0;
        tick();
        chk("st_then_fetch_req", 64'(mem_req_o), 64'd1);
        chk("st_then_fetch_addr", 64'(mem_addr_o), 64'h44);
        tick();
        chk("st_fetch_done", 64'(if_done_o), 64'd1);
        chk("st_fetch_rdata", 64'(if_rdata_o), 64'(mem_model(32'h44)));
        if_req_i = 1'b0;
        tick();

        // Streak: held fetch against continuous data loads.
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_be_i = 4'h3;
        if_req_i = 1'b1; if_addr_i = 32'h48;
        for (int k = 0; k < 4; k++) push_d(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h3);
        push_i(32'h48);
        for (int k = 4; k < 6; k++) push_d(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h3);
        dn = 0;
        fetch_at = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            tick();
            if (if_done_o) begin
                fetch_at = dn;
                if_req_i = 1'b0;
            end
            if (d_done_o) begin
                dn++;
                if (dn == 6) begin
                    d_req_i = 1'b0;
                    break;
                end
                d_addr_i = 32'h200 + 32'(4 * dn);
            end
        end
        chk("streak_data_count", 64'(dn), 64'd6);
        chk("streak_fetch_slot", 64'(fetch_at), 64'd4);
        tick();

        // Reset during GNT_D, then a stray ack.
        mem_delay = 5;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500; d_be_i = 4'hF;
        push_d(1'b0, 32'h500, 32'h0, 4'hF);
        tick();
        chk("rm_req", 64'(mem_req_o), 64'd1);
        tick();
        reset_i = 1'b1;
        d_req_i = 1'b0;
        tick();
        chk("rm_req_drop", 64'(mem_req_o), 64'd0);
        chk("rm_busy", 64'(busy_o), 64'd0);
        chk("rm_no_done", 64'(d_done_o), 64'd0);
        chk("rm_addr", 64'(mem_addr_o), 64'd0);
        chk("rm_rdata", {if_rdata_o, d_rdata_o}, 64'd0);
        reset_i = 1'b0;
        force_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rm_ack_ignored_done", 64'(d_done_o), 64'd0);
            chk("rm_ack_ignored_req", 64'(mem_req_o), 64'd0);
            chk("rm_ack_ignored_busy", 64'(busy_o), 64'd0);
        end
        force_ack = 1'b0;

        // Enable gating, and enable dropped mid-access.
        mem_delay = 0;
        enable_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600; d_be_i = 4'hF;
        if_req_i = 1'b1; if_addr_i = 32'h60;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("en_off_req", 64'(mem_req_o), 64'd0);
            chk("en_off_busy", 64'(busy_o), 64'd0);
        end
        enable_i = 1'b1;
        push_d(1'b0, 32'h600, 32'h0, 4'hF);
        push_i(32'h60);
        tick();
        chk("en_on_req", 64'(mem_req_o), 64'd1);
        chk("en_on_addr", 64'(mem_addr_o), 64'h600);
        enable_i = 1'b0;
        tick();
        chk("en_mid_done", 64'(d_done_o), 64'd1);
        chk("en_mid_rdata", 64'(d_rdata_o), 64'(mem_model(32'h600)));
        d_req_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("en_mid_no_grant", 64'(mem_req_o), 64'd0);
        end
        enable_i = 1'b1;
        tick();
        chk("en_fetch_req", 64'(mem_req_o), 64'd1);
        chk("en_fetch_addr", 64'(mem_addr_o), 64'h60);
        tick();
        chk("en_fetch_done", 64'(if_done_o), 64'd1);
        if_req_i = 1'b0;

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_D_STREAK, default 4, meaning consecutive data grants allowed while fetch waits.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be: clk_i in 1, clock; reset_i in 1, sync active-high reset.
REQ-006 Control port: enable_i in 1; when low, no new grants are issued.
REQ-007 Fetch ports: if_req_i in 1; if_addr_i in ADDR_W; if_rdata_o out DATA_W; if_done_o out 1, one-cycle completion pulse.
REQ-008 Data ports: d_req_i in 1; d_we_i in 1; d_addr_i in ADDR_W; d_wdata_i in DATA_W; d_be_i in DATA_W/8; d_rdata_o out DATA_W; d_done_o out 1.
REQ-009 Memory ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out ADDR_W; mem_wdata_o out DATA_W; mem_be_o out DATA_W/8; mem_ack_i in 1; mem_rdata_i in DATA_W.
REQ-010 Status port: busy_o out 1, high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, GNT_I and GNT_D; all outputs SHALL be registered.
REQ-012 Requesters SHALL hold req and operands stable until their done pulse; the block SHALL capture address, write data, byte enables and we at grant.
REQ-013 In IDLE with enable_i=1, the block SHALL grant at the clock edge: data wins over fetch unless the streak counter equals MAX_D_STREAK, in which case fetch wins.
REQ-014 In IDLE, a requester whose done output is currently high SHALL be ineligible for that cycle, so a completed request is never re-granted.
REQ-015 In GNT_x, mem_req_o SHALL be 1 with the captured fields; for fetch, mem_we_o=0 and mem_be_o is all ones.
REQ-016 When mem_ack_i is sampled 1 in GNT_x, the next cycle SHALL have state IDLE, mem_req_o=0, x_done_o=1 for exactly one cycle, and x_rdata_o=mem_rdata_i for reads.
REQ-017 On data writes, d_rdata_o SHALL hold its previous value.
REQ-018 Minimum latency with zero-wait memory (ack in the first GNT cycle) SHALL be 2 cycles from request seen in IDLE to done; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-019 The streak counter SHALL increment on each data grant while if_req_i is eligible, saturate at MAX_D_STREAK, and clear on a fetch grant or any IDLE cycle with if_req_i=0.
REQ-020 mem_ack_i SHALL be ignored in IDLE.
REQ-021 enable_i=0 during GNT_x SHALL NOT abort the access; the access completes normally and no further grant follows.
REQ-022 Simultaneous eligible requests with counter below MAX_D_STREAK SHALL grant data.

Reset
REQ-023 With reset_i=1 at an edge, the block SHALL set: state IDLE, streak 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, mem_be_o 0, if_done_o 0, d_done_o 0, if_rdata_o 0, d_rdata_o 0, busy_o 0.
REQ-024 Reset mid-access SHALL drop mem_req_o on the next edge with no done pulse; an ack arriving afterwards SHALL be ignored.

Structure
REQ-025 State encodings and the ADDR_W/DATA_W defaults SHALL live in the shared memory-defines header included by the CPU sources.
REQ-026 No sub-module is needed: one FSM, one saturating counter and capture registers in a single module.

Verification
REQ-027 Single fetch, if_addr_i=0x40, zero-wait memory returning 0x8C010004 -> if_done_o pulses 2 cycles after the request is seen; if_rdata_o=0x8C010004; mem_we_o=0 throughout.
REQ-028 Simultaneous fetch 0x44 and store to 0x100 (wdata 0xDEADBEEF, be 0xF) -> data granted first (mem_we_o=1, mem_addr_o=0x100), then fetch; d_rdata_o unchanged.
REQ-029 Continuous data requests plus a held fetch, MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
REQ-030 Memory ack delayed 3 cycles on a data load -> mem_req_o and mem_addr_o stable for 4 cycles, busy_o=1, single d_done_o pulse, no re-grant in the done cycle.
REQ-031 reset_i asserted in GNT_D before ack, with ack then arriving -> all outputs at reset values next cycle, no d_done_o, state stays IDLE.
REQ-032 enable_i=0 with both requests pending -> no mem_req_o; raising enable_i -> data granted on the next edge.
